// File: rtl/uart_fifo_if.sv
// Byte-stream handshake bundle between a host and the buffered UART.
// master = host side (offers TX bytes, consumes RX bytes); slave = UART side.
interface uart_fifo_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;

   modport master (output tx_valid, tx_data, rx_ready,
                   input  tx_ready, rx_valid, rx_data);
   modport slave  (input  tx_valid, tx_data, rx_ready,
                   output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/uart_fifo.sv
// Buffered 8N1 UART: TX FIFO feeding a serializer, RX deserializer feeding a
// first-word-fall-through FIFO, with sticky overflow / framing error flags.
module uart_fifo #(
   parameter int FREQUENCY = 50_000_000,
   parameter int BPS       = 115200,
   parameter int DEPTH     = 16,
   parameter int STOP_BITS = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   uart_fifo_if.slave             bus,
   output logic                   serial_out,
   input  logic                   serial_in,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic [$clog2(DEPTH):0] rx_level,
   output logic                   rx_overflow,
   output logic                   rx_frame_error,
   input  logic                   clear_errors
);
   localparam int DIV      = (FREQUENCY + BPS / 2) / BPS;
   localparam int AW       = $clog2(DEPTH);
   localparam int LW       = AW + 1;
   localparam int STOP_CYC = STOP_BITS * DIV;
   localparam int CW       = $clog2(STOP_CYC) + 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
   localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

   if (DIV < 4) begin : g_bad_div
      $error("uart_fifo: bit period below 4 clock cycles");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_fifo: DEPTH must be a power of two >= 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_fifo: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                             RX_WAIT_HIGH = 3'd4} rx_state_t;

   // ---------------- TX FIFO ----------------
   logic [7:0]    tx_mem_q [DEPTH];
   logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [LW-1:0] tx_level_q, tx_level_d;
   logic          tx_ready_q, tx_ready_d;
   logic          tx_push_s, tx_pop_s;

   assign tx_push_s    = bus.tx_valid & tx_ready_q;
   assign bus.tx_ready = tx_ready_q;
   assign tx_level     = tx_level_q;

   // TX FIFO pointer/occupancy next state; ready derives from next occupancy only.
   always_comb begin
      tx_wr_d    = tx_push_s ? (tx_wr_q + AW'(1)) : tx_wr_q;
      tx_rd_d    = tx_pop_s  ? (tx_rd_q + AW'(1)) : tx_rd_q;
      tx_level_d = tx_level_q;
      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_level_d = tx_level_q + LW'(1);
         2'b01:   tx_level_d = tx_level_q - LW'(1);
         default: tx_level_d = tx_level_q;
      endcase
      tx_ready_d = (tx_level_d != LVL_FULL);
   end

   // TX FIFO storage write (contents are don't-care while level is 0).
   always_ff @(posedge clock) begin
      if (tx_push_s) tx_mem_q[tx_wr_q] <= bus.tx_data;
   end

   // ---------------- TX serializer ----------------
   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          serial_out_q, serial_out_d;

   assign serial_out = serial_out_q;

   // TX FSM next state; the line level is registered so it changes with the state.
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_cnt_d     = tx_cnt_q;
      tx_bit_d     = tx_bit_q;
      tx_shift_d   = tx_shift_q;
      serial_out_d = serial_out_q;
      tx_pop_s     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_level_q != LVL_ZERO) begin
               tx_pop_s     = 1'b1;
               tx_shift_d   = tx_mem_q[tx_rd_q];
               tx_cnt_d     = CW'(0);
               tx_state_d   = TX_START;
               serial_out_d = 1'b0;
            end else begin
               serial_out_d = 1'b1;
            end
         end
         TX_START: begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d     = CW'(0);
               tx_bit_d     = 3'd0;
               tx_state_d   = TX_DATA;
               serial_out_d = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = CW'(0);
               if (tx_bit_q == 3'd7) begin
                  tx_state_d   = TX_STOP;
                  serial_out_d = 1'b1;
               end else begin
                  tx_bit_d     = tx_bit_q + 3'd1;
                  tx_shift_d   = {1'b0, tx_shift_q[7:1]};
                  serial_out_d = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == STOP_LAST) begin
               tx_cnt_d   = CW'(0);
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         default: begin
            tx_state_d   = TX_IDLE;
            serial_out_d = 1'b1;
         end
      endcase
   end

   // TX state, FIFO bookkeeping and line register; reset aborts any frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_wr_q      <= AW'(0);
         tx_rd_q      <= AW'(0);
         tx_level_q   <= LVL_ZERO;
         tx_ready_q   <= 1'b1;
         tx_state_q   <= TX_IDLE;
         tx_cnt_q     <= CW'(0);
         tx_bit_q     <= 3'd0;
         tx_shift_q   <= 8'd0;
         serial_out_q <= 1'b1;
      end else begin
         tx_wr_q      <= tx_wr_d;
         tx_rd_q      <= tx_rd_d;
         tx_level_q   <= tx_level_d;
         tx_ready_q   <= tx_ready_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         serial_out_q <= serial_out_d;
      end
   end

   // ---------------- RX deserializer ----------------
   logic          rx_meta_q, rx_sync_q;
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_push_s, rx_ferr_set_s;

   // RX FSM next state; all sampling uses the synchronized line only.
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_push_s     = 1'b0;
      rx_ferr_set_s = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_sync_q) begin
               rx_cnt_d   = CW'(0);
               rx_state_d = RX_START;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = CW'(0);
               rx_bit_d   = 3'd0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = CW'(0);
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d = CW'(0);
               if (rx_sync_q) begin
                  rx_push_s  = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_ferr_set_s = 1'b1;
                  rx_state_d    = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_sync_q) begin
               rx_state_d = RX_IDLE;
            end else begin
               rx_state_d = RX_WAIT_HIGH;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]    rx_mem_q [DEPTH];
   logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [LW-1:0] rx_level_q, rx_level_d;
   logic          rx_valid_q, rx_valid_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_pop_s, rx_full_s, rx_wr_en_s, rx_ovf_set_s;
   logic          rx_overflow_q, rx_overflow_d, rx_frame_error_q, rx_frame_error_d;

   assign rx_pop_s     = rx_valid_q & bus.rx_ready;
   assign rx_full_s    = (rx_level_q == LVL_FULL);
   assign rx_wr_en_s   = rx_push_s & (~rx_full_s | rx_pop_s);
   assign rx_ovf_set_s = rx_push_s & rx_full_s & ~rx_pop_s;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign rx_level       = rx_level_q;
   assign rx_overflow    = rx_overflow_q;
   assign rx_frame_error = rx_frame_error_q;

   // RX FIFO next state; registered head tracks whichever entry is at the read pointer next.
   always_comb begin
      rx_wr_d    = rx_wr_en_s ? (rx_wr_q + AW'(1)) : rx_wr_q;
      rx_rd_d    = rx_pop_s   ? (rx_rd_q + AW'(1)) : rx_rd_q;
      rx_level_d = rx_level_q;
      case ({rx_wr_en_s, rx_pop_s})
         2'b10:   rx_level_d = rx_level_q + LW'(1);
         2'b01:   rx_level_d = rx_level_q - LW'(1);
         default: rx_level_d = rx_level_q;
      endcase
      rx_valid_d = (rx_level_d != LVL_ZERO);
      if (rx_level_d == LVL_ZERO) begin
         rx_data_d = rx_data_q;
      end else if (rx_wr_en_s && (rx_rd_d == rx_wr_q)) begin
         rx_data_d = rx_shift_q;
      end else begin
         rx_data_d = rx_mem_q[rx_rd_d];
      end
      if (rx_ovf_set_s) begin
         rx_overflow_d = 1'b1;
      end else if (clear_errors) begin
         rx_overflow_d = 1'b0;
      end else begin
         rx_overflow_d = rx_overflow_q;
      end
      if (rx_ferr_set_s) begin
         rx_frame_error_d = 1'b1;
      end else if (clear_errors) begin
         rx_frame_error_d = 1'b0;
      end else begin
         rx_frame_error_d = rx_frame_error_q;
      end
   end

   // RX FIFO storage write; dropped bytes never reach the array.
   always_ff @(posedge clock) begin
      if (rx_wr_en_s) rx_mem_q[rx_wr_q] <= rx_shift_q;
   end

   // RX synchronizer, FSM, FIFO bookkeeping and sticky flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q        <= 1'b1;
         rx_sync_q        <= 1'b1;
         rx_state_q       <= RX_IDLE;
         rx_cnt_q         <= CW'(0);
         rx_bit_q         <= 3'd0;
         rx_shift_q       <= 8'd0;
         rx_wr_q          <= AW'(0);
         rx_rd_q          <= AW'(0);
         rx_level_q       <= LVL_ZERO;
         rx_valid_q       <= 1'b0;
         rx_data_q        <= 8'd0;
         rx_overflow_q    <= 1'b0;
         rx_frame_error_q <= 1'b0;
      end else begin
         rx_meta_q        <= serial_in;
         rx_sync_q        <= rx_meta_q;
         rx_state_q       <= rx_state_d;
         rx_cnt_q         <= rx_cnt_d;
         rx_bit_q         <= rx_bit_d;
         rx_shift_q       <= rx_shift_d;
         rx_wr_q          <= rx_wr_d;
         rx_rd_q          <= rx_rd_d;
         rx_level_q       <= rx_level_d;
         rx_valid_q       <= rx_valid_d;
         rx_data_q        <= rx_data_d;
         rx_overflow_q    <= rx_overflow_d;
         rx_frame_error_q <= rx_frame_error_d;
      end
   end
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo at DIV=16, DEPTH=4: serial waveform
// reference, loopback traffic against a byte-order queue model, overflow,
// framing error, glitch rejection and mid-frame reset.
module tb_uart_fifo;
   logic       clock;
   logic       reset_n;
   logic       serial_out;
   logic       serial_in;
   logic [2:0] tx_level;
   logic [2:0] rx_level;
   logic       rx_overflow;
   logic       rx_frame_error;
   logic       clear_errors;
   logic       loopback;
   logic       drv_si;

   int n_checks;
   int n_pass;

   logic [7:0] exp_q[$];
   logic [7:0] pending_q[$];
   logic [7:0] sent[5];

   uart_fifo_if bus ();

   uart_fifo #(
      .FREQUENCY(16),
      .BPS      (1),
      .DEPTH    (4),
      .STOP_BITS(1)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .bus           (bus.slave),
      .serial_out    (serial_out),
      .serial_in     (serial_in),
      .tx_level      (tx_level),
      .rx_level      (rx_level),
      .rx_overflow   (rx_overflow),
      .rx_frame_error(rx_frame_error),
      .clear_errors  (clear_errors)
   );

   assign serial_in = loopback ? serial_out : drv_si;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected line level of an 8N1 frame in bit slot 0 (start) .. 9 (stop).
   function automatic logic frame_bit(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      else if (slot <= 8) return b[slot-1];
      else return 1'b1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Drive a whole frame on serial_in from the bench, plus a trailing idle bit time.
   task automatic drive_frame(input logic [7:0] b, input logic stop_v);
      for (int slot = 0; slot < 11; slot++) begin
         for (int k = 0; k < 16; k++) begin
            if (slot == 9) drv_si = stop_v;
            else if (slot == 10) drv_si = 1'b1;
            else drv_si = frame_bit(b, slot);
            @(negedge clock);
         end
      end
   endtask

   // Push pending_q bytes into TX as tx_ready allows, within a cycle budget.
   task automatic push_all(input int budget);
      for (int c = 0; c < budget && pending_q.size() > 0; c++) begin
         if (bus.tx_ready) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = pending_q.pop_front();
         end else begin
            bus.tx_valid = 1'b0;
         end
         @(negedge clock);
      end
      bus.tx_valid = 1'b0;
      check_eq("push_all_done", 32'(pending_q.size()), 32'd0);
   endtask

   // Loopback traffic: every byte in exp_q must come out in order, unaltered.
   task automatic run_loopback(input bit rand_mode, input int budget);
      logic rdy;
      pending_q = exp_q;
      for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
         @(negedge clock);
         if (bus.rx_valid) check_eq("rx_data_head", 32'(bus.rx_data), 32'(exp_q[0]));
         rdy = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         bus.rx_ready = rdy;
         if (bus.rx_valid && rdy) void'(exp_q.pop_front());
         if (pending_q.size() > 0 && bus.tx_ready && (!rand_mode || $urandom_range(0, 3) != 0)) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = pending_q.pop_front();
         end else begin
            bus.tx_valid = 1'b0;
         end
      end
      @(negedge clock);
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b0;
      check_eq("rx_all_delivered", 32'(exp_q.size()), 32'd0);
      check_eq("lb_rx_level", 32'(rx_level), 32'd0);
      check_eq("lb_overflow", 32'(rx_overflow), 32'd0);
      check_eq("lb_frame_err", 32'(rx_frame_error), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int wait_c;
      n_checks = 0;
      n_pass   = 0;
      reset_n      = 1'b0;
      loopback     = 1'b0;
      drv_si       = 1'b1;
      clear_errors = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'd0;
      bus.rx_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      check_eq("rst_serial_out", 32'(serial_out), 32'd1);
      check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check_eq("rst_tx_level", 32'(tx_level), 32'd0);
      check_eq("rst_rx_level", 32'(rx_level), 32'd0);
      check_eq("rst_overflow", 32'(rx_overflow), 32'd0);
      check_eq("rst_frame_err", 32'(rx_frame_error), 32'd0);
      reset_n = 1'b1;

      // Single 0x55 frame waveform
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h55;
      @(negedge clock);
      bus.tx_valid = 1'b0;
      check_eq("tx_level_after_push", 32'(tx_level), 32'd1);
      check_eq("line_idle_before_pop", 32'(serial_out), 32'd1);
      for (int c = 0; c < 160; c++) begin
         @(negedge clock);
         if (c == 0) check_eq("tx_level_after_pop", 32'(tx_level), 32'd0);
         check_eq("tx_wave_55", 32'(serial_out), 32'(frame_bit(8'h55, c / 16)));
      end
      @(negedge clock);
      check_eq("line_idle_after_frame", 32'(serial_out), 32'd1);

      // Loopback, fixed bytes
      loopback = 1'b1;
      exp_q = '{8'hA3, 8'h00, 8'hFF};
      run_loopback(1'b0, 800);

      // Loopback, random bytes with random consumer stalls
      exp_q.delete();
      for (int i = 0; i < 12; i++) exp_q.push_back(8'($urandom_range(0, 255)));
      run_loopback(1'b1, 3200);

      // Overflow: consumer stalled, five bytes sent
      for (int i = 0; i < 5; i++) begin
         sent[i] = 8'($urandom_range(0, 255));
         pending_q.push_back(sent[i]);
      end
      push_all(40);
      wait_c = 0;
      while (!rx_overflow && wait_c < 1200) begin
         @(negedge clock);
         wait_c++;
      end
      repeat (20) @(negedge clock);
      check_eq("ovf_flag", 32'(rx_overflow), 32'd1);
      check_eq("ovf_rx_level", 32'(rx_level), 32'd4);
      check_eq("ovf_no_frame_err", 32'(rx_frame_error), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_eq("ovf_valid", 32'(bus.rx_valid), 32'd1);
         check_eq("ovf_data", 32'(bus.rx_data), 32'(sent[i]));
         bus.rx_ready = 1'b1;
         @(negedge clock);
      end
      bus.rx_ready = 1'b0;
      check_eq("ovf_drained_level", 32'(rx_level), 32'd0);
      check_eq("ovf_flag_sticky", 32'(rx_overflow), 32'd1);
      clear_errors = 1'b1;
      @(negedge clock);
      clear_errors = 1'b0;
      check_eq("ovf_cleared", 32'(rx_overflow), 32'd0);

      // Framing error then a good frame
      loopback = 1'b0;
      drv_si   = 1'b1;
      repeat (4) @(negedge clock);
      drive_frame(8'h3C, 1'b0);
      check_eq("ferr_flag", 32'(rx_frame_error), 32'd1);
      check_eq("ferr_rx_level", 32'(rx_level), 32'd0);
      drive_frame(8'h12, 1'b1);
      check_eq("after_ferr_valid", 32'(bus.rx_valid), 32'd1);
      check_eq("after_ferr_data", 32'(bus.rx_data), 32'h12);
      check_eq("after_ferr_level", 32'(rx_level), 32'd1);
      check_eq("ferr_sticky", 32'(rx_frame_error), 32'd1);
      bus.rx_ready = 1'b1;
      clear_errors = 1'b1;
      @(negedge clock);
      bus.rx_ready = 1'b0;
      clear_errors = 1'b0;
      check_eq("ferr_cleared", 32'(rx_frame_error), 32'd0);
      check_eq("ferr_popped_level", 32'(rx_level), 32'd0);

      // Short low glitch is rejected
      drv_si = 1'b0;
      repeat (5) @(negedge clock);
      drv_si = 1'b1;
      repeat (60) @(negedge clock);
      check_eq("glitch_level", 32'(rx_level), 32'd0);
      check_eq("glitch_overflow", 32'(rx_overflow), 32'd0);
      check_eq("glitch_frame_err", 32'(rx_frame_error), 32'd0);

      // Reset mid-data-bit aborts TX and empties the FIFO
      for (int i = 0; i < 4; i++) begin
         bus.tx_valid = 1'b1;
         bus.tx_data  = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         @(negedge clock);
      end
      bus.tx_valid = 1'b0;
      repeat (36) @(negedge clock);
      check_eq("pre_rst_line_low", 32'(serial_out), 32'd0);
      check_eq("pre_rst_tx_level", 32'(tx_level), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      check_eq("midrst_serial_out", 32'(serial_out), 32'd1);
      check_eq("midrst_tx_level", 32'(tx_level), 32'd0);
      check_eq("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      lows = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (!serial_out) lows++;
      end
      check_eq("no_tx_after_rst", 32'(lows), 32'd0);
      check_eq("post_rst_tx_level", 32'(tx_level), 32'd0);

      // First push right after reset release is accepted
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hC5;
      @(negedge clock);
      bus.tx_valid = 1'b0;
      check_eq("first_push_after_rst", 32'(tx_level), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter FREQUENCY, default 50_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 115200: serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 16: entries per FIFO; power of two, at least 2.
REQ-004 SHALL have parameter STOP_BITS, default 1: TX stop bits, 1 or 2; RX always checks one.
REQ-005 clock  input  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 tx_valid  input  1  TX byte offered.
REQ-008 tx_data  input  8  TX byte.
REQ-009 tx_ready  output  1  TX FIFO not full.
REQ-010 rx_valid  output  1  RX FIFO not empty.
REQ-011 rx_data  output  8  RX FIFO head; first-word-fall-through.
REQ-012 rx_ready  input  1  consumer takes head.
REQ-013 serial_out  output  1  TX line, idle high.
REQ-014 serial_in  input  1  RX line, asynchronous to clock.
REQ-015 tx_level, rx_level  output  $clog2(DEPTH)+1 each  current FIFO occupancy.
REQ-016 rx_overflow  output  1  sticky: RX byte dropped because FIFO full.
REQ-017 rx_frame_error  output  1  sticky: RX stop bit sampled low.
REQ-018 clear_errors  input  1  one-cycle pulse clears both sticky flags.

Function
REQ-019 Bit period SHALL be DIV = (FREQUENCY + BPS/2) / BPS cycles; DIV < 4 SHALL be an elaboration error.
REQ-020 TX push SHALL occur on tx_valid & tx_ready; tx_ready SHALL depend only on registered occupancy, with no combinational path from tx_valid.
REQ-021 TX FSM states: IDLE, START, DATA, STOP.
- IDLE: if FIFO non-empty, pop head; enter START next cycle.
- START: drive 0 for DIV cycles.
- DATA: drive 8 bits LSB first, DIV cycles each.
- STOP: drive 1 for STOP_BITS*DIV cycles, then IDLE.
REQ-022 Back-to-back TX bytes SHALL have at most one idle-high cycle between the stop bit and the next start bit.
REQ-023 serial_in SHALL pass through a two-flop synchronizer before any use.
REQ-024 RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: synchronized low enters START.
- START: after DIV/2 cycles resample; high means glitch, return to IDLE with no flags; low enters DATA.
- DATA: sample every DIV cycles, 8 bits LSB first.
- STOP: sample after DIV cycles; high pushes byte and returns to IDLE; low sets rx_frame_error, discards byte, enters WAIT_HIGH.
- WAIT_HIGH: return to IDLE on first synchronized high.
REQ-025 RX push into a full FIFO without a same-cycle pop SHALL drop the byte, set rx_overflow, and leave the FIFO contents unchanged.
- With a same-cycle pop the byte SHALL be accepted.
REQ-026 RX pop SHALL occur on rx_valid & rx_ready; rx_data SHALL be stable while rx_valid=1 and no pop occurs.
REQ-027 Simultaneous push and pop SHALL leave the level unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-029 A flag set event SHALL win over clear_errors in the same cycle.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 While reset_n=0, asynchronously:
- serial_out=1, tx_ready=1, rx_valid=0, rx_data=0;
- both levels 0, both flags 0;
- both FSMs IDLE, synchronizer flops 1.
REQ-032 Reset mid-frame SHALL abort the frame, discard all FIFO contents, and drive serial_out high immediately.
REQ-033 After reset_n rises, the first push SHALL be accepted on the first clock edge.

Verification (FREQUENCY=16, BPS=1, DIV=16, DEPTH=4)
REQ-034 Push 0x55 -> serial_out:
- 0 for 16 cycles;
- then 1,0,1,0,1,0,1,0 at 16 cycles each;
- then 1 for 16 cycles;
- tx_level 1 -> 0 at pop.
REQ-035 Loopback serial_out->serial_in, push 0xA3, 0x00, 0xFF -> rx_data delivers 0xA3, 0x00, 0xFF in order; both flags stay 0.
REQ-036 Loopback with rx_ready=0, send 5 bytes -> rx_level=4, rx_overflow=1, first 4 bytes intact; clear_errors pulse -> rx_overflow=0.
REQ-037 Drive frame 0x3C with stop bit low -> rx_frame_error=1, rx_level stays 0; next valid frame 0x12 is received.
REQ-038 Drive serial_in low for 5 cycles -> no byte pushed, no flags set.
REQ-039 Push 4 bytes, assert reset_n=0 mid-data-bit -> serial_out=1 and tx_level=0 immediately; no further frames transmitted.
